// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - flag bit positions and buffer occupancy encoding for the ALU writeback stage
package alu_pkg;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic logic [1:0] occ_count(input occ_t s);
    case (s)
      OCC_ONE:  occ_count = 2'd1;
      OCC_FULL: occ_count = 2'd2;
      default:  occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/result_skid_buf.sv
// rtl/result_skid_buf.sv - two-entry in-order result buffer; in_ready comes only from registered state
module result_skid_buf
  import alu_pkg::*;
#(
  parameter int W           = 10,
  parameter int DEPTH_FIXED = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         push
);

  localparam logic [1:0] DEPTH_L = 2'(DEPTH_FIXED);

  occ_t         state;
  occ_t         state_nxt;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         rdy_q;
  logic         pop;

  always_comb begin
    push      = in_valid & rdy_q;
    pop       = (state != OCC_EMPTY) & out_ready;
    state_nxt = state;
    case (state)
      OCC_EMPTY: if (push) state_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_nxt = OCC_FULL;
        else if (!push && pop) state_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_nxt = OCC_ONE;
      default:   state_nxt = OCC_EMPTY;
    endcase
  end

  // rdy_q is held low through reset so in_ready only rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
      ent0  <= '0;
      ent1  <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (occ_count(state_nxt) < DEPTH_L);
      case (state)
        OCC_EMPTY: if (push) ent0 <= in_data;
        OCC_ONE: begin
          if (push && pop) ent0 <= in_data;
          else if (push)   ent1 <= in_data;
        end
        OCC_FULL:  if (pop) ent0 <= ent1;
        default: ;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = (state == OCC_EMPTY) ? '0 : ent0;

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - ALU result writeback buffer and flags register; ALU_WB_STICKY_V_EN makes V sticky
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DEST_W      = 2,
  parameter int DEPTH_FIXED = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_sum,
  input  logic              in_cout,
  input  logic              in_overflow,
  input  logic              in_no,
  input  logic              in_zo,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags,
  input  logic              flag_clr
);

  localparam int W = 8 + DEST_W;

  logic [W-1:0] buf_out;
  logic         push;
  logic         v_next;

  result_skid_buf #(
    .W           (W),
    .DEPTH_FIXED (DEPTH_FIXED)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_dest, in_sum}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out),
    .push      (push)
  );

  assign out_data = buf_out[7:0];
  assign out_dest = buf_out[W-1:8];

`ifdef ALU_WB_STICKY_V_EN
  assign v_next = flags[FLAG_V] | in_overflow;
`else
  assign v_next = in_overflow;
`endif

  // flags follow acceptance, not drain, so they update even while the buffer is backed up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_clr) begin
      flags <= '0;
    end else if (push && in_flag_we) begin
      flags[FLAG_C] <= in_cout;
      flags[FLAG_V] <= v_next;
      flags[FLAG_N] <= in_no;
      flags[FLAG_Z] <= in_zo;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - self-checking bench for alu_writeback_stage with queue-based reference model
module tb_alu_writeback_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       in_cout, in_overflow, in_no, in_zo;
  logic [1:0] in_dest;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic [3:0] flags;
  logic       flag_clr;

  int n_tests = 0;
  int n_fail  = 0;

  alu_writeback_stage #(.DEST_W(2), .DEPTH_FIXED(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_cout     (in_cout),
    .in_overflow (in_overflow),
    .in_no       (in_no),
    .in_zo       (in_zo),
    .in_dest     (in_dest),
    .in_flag_we  (in_flag_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .flags       (flags),
    .flag_clr    (flag_clr)
  );

  always #5 clk = ~clk;

  // reference model: FIFO of accepted results plus a flags word
  logic [7:0] m_sum[$];
  logic [1:0] m_dst[$];
  logic [3:0] m_flags;
  logic       m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum.delete();
      m_dst.delete();
      m_flags = 4'b0;
      m_rdy   = 1'b0;
    end else begin
      automatic logic acc = in_valid && m_rdy;
      automatic logic pop = (m_sum.size() > 0) && out_ready;
      if (flag_clr) m_flags = 4'b0;
      else if (acc && in_flag_we) begin
`ifdef ALU_WB_STICKY_V_EN
        m_flags = {in_cout, in_overflow | m_flags[2], in_no, in_zo};
`else
        m_flags = {in_cout, in_overflow, in_no, in_zo};
`endif
      end
      if (pop) begin
        void'(m_sum.pop_front());
        void'(m_dst.pop_front());
      end
      if (acc) begin
        m_sum.push_back(in_sum);
        m_dst.push_back(in_dest);
      end
      m_rdy = (m_sum.size() < 2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("mdl_out_valid", 32'(out_valid), 32'(m_sum.size() > 0));
    check("mdl_out_data", 32'(out_data), (m_sum.size() > 0) ? 32'(m_sum[0]) : 32'd0);
    check("mdl_out_dest", 32'(out_dest), (m_dst.size() > 0) ? 32'(m_dst[0]) : 32'd0);
    check("mdl_in_ready", 32'(in_ready), 32'(m_rdy));
    check("mdl_flags", 32'(flags), 32'(m_flags));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic [1:0] d,
                       input logic [3:0] cvnz, input logic we);
    in_valid    = v;
    in_sum      = s;
    in_dest     = d;
    in_cout     = cvnz[3];
    in_overflow = cvnz[2];
    in_no       = cvnz[1];
    in_zo       = cvnz[0];
    in_flag_we  = we;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 2'd0, 4'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    idle();
    cyc(); cyc();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // single pass
    out_ready = 1'b1;
    drive(1'b1, 8'h7F, 2'd1, 4'b0, 1'b0);
    cyc(); idle();
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_data", 32'(out_data), 32'h7F);
    check("pass_dest", 32'(out_dest), 32'd1);
    cyc();
    check("pass_empty", 32'(out_valid), 32'd0);
    check("pass_zero", 32'(out_data), 32'd0);

    // backpressure, third push ignored including its flags
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'd2, 4'b0, 1'b0); cyc();
    drive(1'b1, 8'h22, 2'd3, 4'b0, 1'b0); cyc();
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h33, 2'd1, 4'b1111, 1'b1); cyc();
    idle();
    check("bp_hold", 32'(out_data), 32'h11);
    check("bp_noflag", 32'(flags), 32'd0);
    out_ready = 1'b1; cyc();
    check("bp_second", 32'(out_data), 32'h22);
    check("bp_second_dest", 32'(out_dest), 32'd3);
    cyc();
    check("bp_drained", 32'(out_valid), 32'd0);

    // simultaneous push and pop in ONE
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 2'd0, 4'b0, 1'b0); cyc();
    out_ready = 1'b1;
    drive(1'b1, 8'h55, 2'd2, 4'b0, 1'b0); cyc();
    idle();
    check("pp_data", 32'(out_data), 32'h55);
    check("pp_rdy", 32'(in_ready), 32'd1);
    cyc();

    // flags load and clear priority
    drive(1'b1, 8'h00, 2'd0, 4'b1101, 1'b1); cyc();
    check("flg_load", 32'(flags), 32'b1101);
    flag_clr = 1'b1;
    drive(1'b1, 8'h00, 2'd0, 4'b1101, 1'b1); cyc();
    flag_clr = 1'b0;
    check("flg_clr_prio", 32'(flags), 32'd0);

    // V behaviour across two loads
    drive(1'b1, 8'h80, 2'd1, 4'b0110, 1'b1); cyc();
    drive(1'b1, 8'h01, 2'd1, 4'b0000, 1'b1); cyc();
    idle();
`ifdef ALU_WB_STICKY_V_EN
    check("flg_v_sticky", 32'(flags), 32'b0100);
`else
    check("flg_v_plain", 32'(flags), 32'b0000);
`endif
    flag_clr = 1'b1; cyc(); flag_clr = 1'b0;
    check("flg_v_cleared", 32'(flags), 32'd0);

    // mixed traffic pattern
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0) || (i > 18);
      drive((i % 3) != 0, 8'(i * 7 + 3), 2'(i), 4'(i), (i % 4) == 1);
      cyc();
    end
    idle();
    out_ready = 1'b1;
    cyc(); cyc();

    // reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 8'h0C, 2'd1, 4'b1010, 1'b1); cyc();
    drive(1'b1, 8'h0D, 2'd2, 4'b0000, 1'b0); cyc();
    idle();
    check("mf_full", 32'(in_ready), 32'd0);
    check("mf_flags_set", 32'(flags), 32'b1010);
    rst_n = 1'b0;
    #1;
    check("mf_rst_valid", 32'(out_valid), 32'd0);
    check("mf_rst_flags", 32'(flags), 32'd0);
    check("mf_rst_rdy", 32'(in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("mf_rel_rdy", 32'(in_ready), 32'd1);
    check("mf_rel_valid", 32'(out_valid), 32'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 SHALL have parameter DEST_W, default 2, width of the destination-register tag.
REQ-002 SHALL have parameter DEPTH_FIXED, default 2, buffer depth; only the value 2 is legal.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream result present.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-007 SHALL have port in_sum  input  8  8-bit add/sub result.
REQ-008 SHALL have ports in_cout, in_overflow, in_no, in_zo  input  1 each  carry, signed overflow, negative and zero from the 8-bit math unit.
REQ-009 SHALL have port in_dest  input  DEST_W  destination register tag.
REQ-010 SHALL have port in_flag_we  input  1  result updates the flags register.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  downstream register file accepts the head entry.
REQ-013 SHALL have port out_data  output  8  head entry sum.
REQ-014 SHALL have port out_dest  output  DEST_W  head entry tag.
REQ-015 SHALL have port flags  output  4  registered {C,V,N,Z}.
REQ-016 SHALL have port flag_clr  input  1  synchronous clear of all four flags.

Function
REQ-017 SHALL hold results in a 2-entry in-order buffer with occupancy states EMPTY, ONE, FULL.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no combinational path from out_ready).
REQ-019 SHALL accept an entry when in_valid and in_ready are both 1; SHALL pop the head when out_valid and out_ready are both 1.
REQ-020 SHALL transition EMPTY->ONE on push, ONE->FULL on push without pop, ONE->EMPTY on pop without push, ONE->ONE on simultaneous push and pop, FULL->ONE on pop.
REQ-021 SHALL present an entry accepted at edge N on out_valid/out_data/out_dest after edge N (1-cycle latency) when the buffer was EMPTY.
REQ-022 SHALL hold out_data/out_dest stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_data and out_dest to 0 when EMPTY.
REQ-024 SHALL, on an accepted entry with in_flag_we=1, load flags <= {in_cout,in_overflow,in_no,in_zo} at that edge, independent of buffer drain.
REQ-025 SHALL give flag_clr priority over a simultaneous flag load; flags become 0.
REQ-026 SHALL ignore in_* inputs when not accepted (in_valid=0 or FULL).

Reset
REQ-027 SHALL, while rst_n=0, force state EMPTY, out_valid=0, out_data=0, out_dest=0, flags=0, in_ready=0.
REQ-028 SHALL discard any buffered entries on reset mid-operation; in_ready rises in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro ALU_WB_STICKY_V_EN defined, OR in_overflow into flags.V (V cleared only by flag_clr or reset); without it V loads like the other flags.

Structure
REQ-030 SHALL place the flag bit-index constants (C=3,V=2,N=1,Z=0) and the occupancy-state encoding in shared package alu_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module result_skid_buf; flags logic stays in the top.

Verification
REQ-032 Reset mid-FULL: two entries held, pulse rst_n low -> out_valid=0, flags=0, in_ready=1 one cycle after release.
REQ-033 Single pass: push sum=0x7F dest=1 with out_ready=1 -> next cycle out_valid=1, out_data=0x7F, out_dest=1; following cycle EMPTY.
REQ-034 Backpressure: out_ready=0, push 0x11 then 0x22 -> in_ready=0 after second; third push 0x33 ignored; release -> 0x11, 0x22 in order.
REQ-035 Simultaneous push/pop in ONE: head 0xAA popped while 0x55 pushed -> state ONE, out_data=0x55 next cycle.
REQ-036 Flags: accept 0x80+0x80 result (sum=0x00, cout=1, V=1, N=0, Z=1, flag_we=1) -> flags=4'b1101; same edge with flag_clr=1 -> flags=0.
REQ-037 Sticky V (ALU_WB_STICKY_V_EN): V=1 result then V=0 result -> flags.V stays 1 until flag_clr; without macro -> flags.V=0.
